// File: rtl/fetch_decode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_ctrl_if
// Brief    : Fetch/decode bundle: the program_memory fetch path, the register
//            file and EX hazard inputs, and the IF/ID issue outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_decode_ctrl_if;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        rs_zero;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic        stall_pm;
  logic [31:0] id_ins;
  logic [15:0] id_pc;
  logic        issue_valid;
  logic [15:0] bubble_cnt;

  // Environment side: program memory, register file and EX stage.
  modport master (
    output ins, current_address, rs_zero, ex_mem_read, ex_rd,
    input  jmp_loc, pc_mux_sel, stall, stall_pm, id_ins, id_pc,
    input  issue_valid, bubble_cnt
  );

  // Controller side.
  modport slave (
    input  ins, current_address, rs_zero, ex_mem_read, ex_rd,
    output jmp_loc, pc_mux_sel, stall, stall_pm, id_ins, id_pc,
    output issue_valid, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_ctrl
// Brief    : IF/ID register plus decode control. Resolves jumps and zero-test
//            branches in ID, stalls on load-use hazards, squashes wrong-path
//            fetches and steers the program_memory PC.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_ctrl #(
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_JAL  = 6'h03,
  parameter logic [5:0] OP_BEQZ = 6'h04,
  parameter logic [5:0] OP_BNEZ = 6'h05,
  parameter logic [5:0] OP_HALT = 6'h3F
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SQUASH   = 2'd1,
    LU_STALL = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] id_ins_q;
  logic [15:0] id_pc_q;
  logic [15:0] bubble_q;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [15:0] w_target;
  logic        w_is_jump;
  logic        w_hazard;
  logic        w_taken;
  logic [15:0] w_jmp_loc;
  logic        w_pc_mux_sel;
  logic        w_stall;
  logic        w_stall_pm;
  logic        w_issue_valid;

  assign w_opcode  = id_ins_q[31:26];
  assign w_rs      = id_ins_q[20:16];
  assign w_target  = id_ins_q[15:0];
  assign w_is_jump = (w_opcode == OP_J) || (w_opcode == OP_JAL);

  // Jumps never read rs, so only branches and ordinary instructions can be
  // blocked by a load still in EX; register 0 is never a real dependency.
  assign w_hazard = bus.ex_mem_read && (bus.ex_rd == w_rs) &&
                    (bus.ex_rd != 5'd0) && !w_is_jump;

  assign w_taken = w_is_jump ||
                   ((w_opcode == OP_BEQZ) &&  bus.rs_zero) ||
                   ((w_opcode == OP_BNEZ) && !bus.rs_zero);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SQUASH;
    else       state_q <= state_d;
  end

  // Next-state and PC-control decode; hazard outranks halt, halt outranks redirect.
  always_comb begin
    state_d       = state_q;
    w_jmp_loc     = 16'h0000;
    w_pc_mux_sel  = 1'b0;
    w_stall       = 1'b0;
    w_stall_pm    = 1'b0;
    w_issue_valid = 1'b0;
    case (state_q)
      SQUASH: begin
        state_d = RUN;
      end
      HALTED: begin
        w_stall    = 1'b1;
        w_stall_pm = 1'b1;
      end
      RUN, LU_STALL: begin
        if (w_hazard) begin
          w_stall    = 1'b1;
          w_stall_pm = 1'b1;
          state_d    = LU_STALL;
        end else if (w_opcode == OP_HALT) begin
          w_issue_valid = 1'b1;
          w_stall       = 1'b1;
          w_stall_pm    = 1'b1;
          state_d       = HALTED;
        end else if (w_taken) begin
          w_issue_valid = 1'b1;
          w_pc_mux_sel  = 1'b1;
          w_jmp_loc     = w_target;
          state_d       = SQUASH;
        end else begin
          w_issue_valid = 1'b1;
          state_d       = RUN;
        end
      end
      default: begin
        state_d = SQUASH;
      end
    endcase
  end

  // IF/ID pipeline register; holds whenever the PC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ins_q <= 32'h0000_0000;
      id_pc_q  <= 16'h0000;
    end else if (!w_stall) begin
      id_ins_q <= bus.ins;
      id_pc_q  <= bus.current_address;
    end
  end

  // Saturating count of cycles in which nothing was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         bubble_q <= 16'h0000;
    else if (!w_issue_valid && (bubble_q != 16'hFFFF)) bubble_q <= bubble_q + 16'd1;
  end

  assign bus.jmp_loc     = w_jmp_loc;
  assign bus.pc_mux_sel  = w_pc_mux_sel;
  assign bus.stall       = w_stall;
  assign bus.stall_pm    = w_stall_pm;
  assign bus.id_ins      = id_ins_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.issue_valid = w_issue_valid;
  assign bus.bubble_cnt  = bubble_q;

endmodule
`default_nettype wire
